pipe_stage_skid_reg: RTL and testbench
======================================

# pipe_stage_skid_reg

Parametrised pipeline-stage register with valid/ready handshake, synchronous flush and bubble injection, generalising the fixed IF/ID latch to any stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). It supports two build modes: a single-entry register with combinational back-pressure, and a two-entry skid buffer whose `in_ready` is registered. Both modes sustain one transfer per cycle. The block sits between adjacent pipeline stages, and the hazard unit drives its flush input.

## Interface
- `WIDTH`, 32: payload width in bits (PC + instruction + control bundle, packed by the instantiating stage).
- `BUBBLE`, 32'h00000013 zero-extended or truncated to `WIDTH`: payload presented on `out_data` whenever the stage is empty (NOP).
- `SKID`, 1: 0 selects the single-entry mode; 1 selects the two-entry skid buffer.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `flush` input 1: synchronous kill of every held entry.
- `in_valid` input 1: upstream has a payload.
- `in_ready` output 1: stage can accept a payload this cycle.
- `in_data` input `WIDTH`: upstream payload.
- `out_valid` output 1: stage presents a valid payload.
- `out_ready` input 1: downstream accepts this cycle.
- `out_data` output `WIDTH`: presented payload, or `BUBBLE` when `out_valid`=0.
- `occupancy` output 2: number of held entries (0..1 when `SKID`=0, 0..2 when `SKID`=1).

## Operation
- Accept = `in_valid & in_ready`. Issue = `out_valid & out_ready`. Entries are consumed in FIFO order, and no payload is ever duplicated or reordered.
- SKID=0 has a single entry register, `main`.
  - `in_ready` = `!out_valid | out_ready` (combinational).
  - On accept, `main` <= `in_data` and `out_valid` <= 1.
  - On issue without accept, `out_valid` <= 0.
- SKID=1 has entries `main` (the output side) and `skid`, with states EMPTY, BUSY and FULL.
  - EMPTY: accept loads `main` and moves to BUSY.
  - BUSY:
    - Accept with issue reloads `main` and stays BUSY.
    - Accept without issue loads `skid` and moves to FULL.
    - Issue without accept moves to EMPTY.
  - FULL: `in_ready`=0. Issue moves `skid` into `main` and goes to BUSY.
  - `in_ready` is a flop output, equal to 1 exactly when the state is not FULL. It has no combinational path from `out_ready`.
- `out_valid` = (state != EMPTY). `out_data` = `main` when valid, else `BUBBLE`. `occupancy` is a flop-derived value.
- Flush:
  - Next state is EMPTY (or `out_valid` <= 0 in SKID=0), and `main`/`skid` are set to `BUBBLE`.
  - An accept in the same cycle is discarded: the upstream handshake completes, but the data is dropped.
  - An issue in the same cycle still completes downstream, because the output was valid during that cycle.
- Reset dominates flush. Flush dominates accept and issue bookkeeping.
- Payload registers update only on accept, skid transfer, flush or reset. There is no spurious capture when `in_valid`=0.

## Timing
- Reset, sampled at a rising edge with `rst_n`=0, gives:
  - `out_valid`=0 and `out_data`=`BUBBLE`.
  - `occupancy`=0.
  - `in_ready`=1 in SKID=1; in SKID=0 it follows its equation and so is also 1.
- Latency is 1 cycle: data accepted at edge N appears on `out_data` with `out_valid`=1 after edge N.
- Throughput is 1 transfer/cycle in both modes while `out_ready`=1.
- SKID=1 back-pressure:
  - `out_ready` falling at cycle N is reflected in `in_ready` after edge N+1.
  - One extra beat can be absorbed by `skid`.
  - The FULL to BUSY transition re-asserts `in_ready` one cycle after the first issue.
- Reset asserted mid-stream (any state) returns to the reset values at the next edge. Held payloads are lost and no issue occurs that cycle beyond what was already visible.
- Flush is effective at the next edge: `out_valid`=0 and `out_data`=`BUBBLE` in the following cycle.

## Test plan
- Reset with SKID=1:
  - Hold `rst_n`=0 for 2 cycles, then release.
  - Required: `out_valid`=0, `out_data`=32'h00000013, `in_ready`=1, `occupancy`=0.
- Streaming:
  - Drive payloads 0x100, 0x104, 0x108 on consecutive cycles with `out_ready`=1.
  - Required: each appears one cycle later, back-to-back, in order. `occupancy` stays at 1.
- Skid fill:
  - In BUSY holding 0xA, drop `out_ready` and accept 0xB.
  - Required: state FULL, `in_ready`=0 the next cycle, `occupancy`=2.
  - Then raise `out_ready`: 0xA then 0xB are issued, and `in_ready`=1 one cycle after 0xA issues.
- Flush while FULL with a simultaneous accept of 0xC:
  - Required: next cycle `out_valid`=0, `out_data`=0x13, `occupancy`=0.
  - 0xC never appears on the output.
- SKID=0 combinational back-pressure:
  - Hold `out_valid`=1 with `out_ready`=0.
  - Required: `in_ready`=0 in the same cycle.
  - Raising `out_ready` raises `in_ready` in the same cycle, and a new payload replaces the old one at the next edge.
- Reset vs. flush:
  - Assert `rst_n`=0 and `flush`=1 together while BUSY.
  - Required: the reset values are reached, and the bubble payload equals `BUBBLE`.

Source files
------------

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, flush and bubble output.
// SKID=0 gives a single entry with combinational back-pressure; SKID=1 gives a
// two-entry skid buffer whose in_ready is registered.
module pipe_stage_skid_reg #(
  parameter int unsigned        WIDTH  = 32,
  parameter logic [WIDTH-1:0]   BUBBLE = WIDTH'(32'h00000013),
  parameter bit                 SKID   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

  logic [WIDTH-1:0] main_q, main_d;
  logic             accept, issue;

  assign accept   = in_valid & in_ready;
  assign issue    = out_valid & out_ready;
  assign out_data = out_valid ? main_q : BUBBLE;

  if (SKID) begin : g_skid
    state_e           state_q, state_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != StEmpty);
    assign occupancy = (state_q == StFull) ? 2'd2 : (state_q == StBusy) ? 2'd1 : 2'd0;

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        // An accept this cycle is dropped; a visible issue already completed.
        state_d = StEmpty;
        main_d  = BUBBLE;
        skid_d  = BUBBLE;
      end else begin
        unique case (state_q)
          StEmpty: begin
            if (accept) begin
              main_d  = in_data;
              state_d = StBusy;
            end
          end
          StBusy: begin
            if (accept && issue) begin
              main_d = in_data;
            end else if (accept) begin
              skid_d  = in_data;
              state_d = StFull;
            end else if (issue) begin
              state_d = StEmpty;
            end
          end
          StFull: begin
            if (issue) begin
              main_d  = skid_q;
              state_d = StBusy;
            end
          end
          default: state_d = StEmpty;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q    <= StEmpty;
        main_q     <= BUBBLE;
        skid_q     <= BUBBLE;
        in_ready_q <= 1'b1;
      end else begin
        state_q    <= state_d;
        main_q     <= main_d;
        skid_q     <= skid_d;
        in_ready_q <= (state_d != StFull);
      end
    end
  end else begin : g_single
    logic valid_q, valid_d;

    assign in_ready  = ~valid_q | out_ready;
    assign out_valid = valid_q;
    assign occupancy = {1'b0, valid_q};

    always_comb begin
      valid_d = valid_q;
      main_d  = main_q;
      if (flush) begin
        valid_d = 1'b0;
        main_d  = BUBBLE;
      end else if (accept) begin
        valid_d = 1'b1;
        main_d  = in_data;
      end else if (issue) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        main_q  <= BUBBLE;
      end else begin
        valid_q <= valid_d;
        main_q  <= main_d;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench: SKID=1 and SKID=0 instances checked against hand-computed values.
module tb_pipe_stage_skid_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fl1, v1, or1, ir1, ov1;
  logic [31:0] d1, od1;
  logic [1:0]  occ1;
  logic        fl0, v0, or0, ir0, ov0;
  logic [31:0] d0, od0;
  logic [1:0]  occ0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.WIDTH(32), .SKID(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (fl1),
    .in_valid  (v1),
    .in_ready  (ir1),
    .in_data   (d1),
    .out_valid (ov1),
    .out_ready (or1),
    .out_data  (od1),
    .occupancy (occ1)
  );

  pipe_stage_skid_reg #(.WIDTH(32), .SKID(1'b0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (fl0),
    .in_valid  (v0),
    .in_ready  (ir0),
    .in_data   (d0),
    .out_valid (ov0),
    .out_ready (or0),
    .out_data  (od0),
    .occupancy (occ0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    fl1 = 1'b0; v1 = 1'b0; or1 = 1'b0; d1 = '0;
    fl0 = 1'b0; v0 = 1'b0; or0 = 1'b0; d0 = '0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("rst_ov1",  32'(ov1),  32'd0);
    check("rst_od1",  od1,       32'h13);
    check("rst_ir1",  32'(ir1),  32'd1);
    check("rst_occ1", 32'(occ1), 32'd0);
    check("rst_ov0",  32'(ov0),  32'd0);
    check("rst_od0",  od0,       32'h13);
    check("rst_ir0",  32'(ir0),  32'd1);

    // Streaming, SKID=1
    or1 = 1'b1; v1 = 1'b1; d1 = 32'h100;
    step();
    check("str0_ov", 32'(ov1), 32'd1);
    check("str0_od", od1, 32'h100);
    check("str0_occ", 32'(occ1), 32'd1);
    d1 = 32'h104;
    step();
    check("str1_od", od1, 32'h104);
    check("str1_occ", 32'(occ1), 32'd1);
    d1 = 32'h108;
    step();
    check("str2_od", od1, 32'h108);
    check("str2_ov", 32'(ov1), 32'd1);
    v1 = 1'b0;
    step();
    check("drain_ov", 32'(ov1), 32'd0);
    check("drain_od", od1, 32'h13);
    check("drain_occ", 32'(occ1), 32'd0);

    // Skid fill
    v1 = 1'b1; d1 = 32'hA;
    step();
    check("busyA_od", od1, 32'hA);
    or1 = 1'b0; d1 = 32'hB;
    #1;
    check("busy_ir", 32'(ir1), 32'd1);
    step();
    check("full_ir", 32'(ir1), 32'd0);
    check("full_occ", 32'(occ1), 32'd2);
    check("full_od", od1, 32'hA);
    v1 = 1'b0; or1 = 1'b1;
    #1;
    check("full_ir_nocomb", 32'(ir1), 32'd0);
    step();
    check("unskid_od", od1, 32'hB);
    check("unskid_ir", 32'(ir1), 32'd1);
    check("unskid_occ", 32'(occ1), 32'd1);

    // Refill to FULL with B held, then flush with 0xC offered
    or1 = 1'b0; v1 = 1'b1; d1 = 32'hD;
    step();
    check("full2_occ", 32'(occ1), 32'd2);
    fl1 = 1'b1; d1 = 32'hC;
    step();
    check("flfull_ov", 32'(ov1), 32'd0);
    check("flfull_od", od1, 32'h13);
    check("flfull_occ", 32'(occ1), 32'd0);
    check("flfull_ir", 32'(ir1), 32'd1);
    fl1 = 1'b0; v1 = 1'b0;
    step();
    check("flfull_noC_ov", 32'(ov1), 32'd0);
    check("flfull_noC_od", od1, 32'h13);

    // Flush in BUSY discards a real accept
    v1 = 1'b1; d1 = 32'hE;
    step();
    check("busyE_od", od1, 32'hE);
    fl1 = 1'b1; d1 = 32'hF;
    step();
    check("flbusy_ov", 32'(ov1), 32'd0);
    fl1 = 1'b0; v1 = 1'b0;
    step();
    check("flbusy_noF_ov", 32'(ov1), 32'd0);
    check("flbusy_noF_od", od1, 32'h13);

    // Reset together with flush while BUSY
    v1 = 1'b1; d1 = 32'h55;
    step();
    check("busy55_od", od1, 32'h55);
    rst_n = 1'b0; fl1 = 1'b1; d1 = 32'h66;
    step();
    check("rstfl_ov", 32'(ov1), 32'd0);
    check("rstfl_od", od1, 32'h13);
    check("rstfl_ir", 32'(ir1), 32'd1);
    check("rstfl_occ", 32'(occ1), 32'd0);
    rst_n = 1'b1; fl1 = 1'b0; v1 = 1'b0;
    step();
    check("rstfl_after_ov", 32'(ov1), 32'd0);

    // SKID=0 combinational back-pressure
    or0 = 1'b0; v0 = 1'b1; d0 = 32'h200;
    step();
    check("s0_ov", 32'(ov0), 32'd1);
    check("s0_od", od0, 32'h200);
    check("s0_occ", 32'(occ0), 32'd1);
    d0 = 32'h204;
    #1;
    check("s0_ir_stall", 32'(ir0), 32'd0);
    step();
    check("s0_hold_od", od0, 32'h200);
    or0 = 1'b1;
    #1;
    check("s0_ir_comb", 32'(ir0), 32'd1);
    step();
    check("s0_replace_od", od0, 32'h204);
    check("s0_replace_ov", 32'(ov0), 32'd1);
    v0 = 1'b0;
    step();
    check("s0_drain_ov", 32'(ov0), 32'd0);
    check("s0_drain_od", od0, 32'h13);
    v0 = 1'b1; d0 = 32'h208;
    step();
    fl0 = 1'b1; d0 = 32'h20C;
    step();
    check("s0_flush_ov", 32'(ov0), 32'd0);
    check("s0_flush_od", od0, 32'h13);
    fl0 = 1'b0; v0 = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
